// File: rtl/hs_lane_serializer.sv
// Multi-lane HS serializer: a word FIFO feeds a 4-phase shifter that emits one bit-pair per lane per clock.
// Latency: 1 clk from FIFO write to pair 0. Byte_ready drops while the FIFO is full. A started byte always completes.
module hs_lane_serializer #(
  parameter int LANES     = 2,
  parameter int DEPTH     = 4,
  parameter int MSB_FIRST = 0
) (
  input  logic                         TX_DDR_clk,
  input  logic                         TX_rst,
  input  logic                         Enable,
  input  logic [LANES*8-1:0]           TX_BYTE_DATA,
  input  logic                         Byte_valid,
  output logic                         Byte_ready,
  output logic [LANES-1:0]             Serial_B1,
  output logic [LANES-1:0]             Serial_B2,
  output logic                         Busy,
  output logic [$clog2(DEPTH+1)-1:0]   Fill_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int W  = LANES * 8;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

  state_t          r_state;
  logic [1:0]      r_phase;
  logic [W-1:0]    r_word;
  logic [W-1:0]    r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic [LANES-1:0] r_b1;
  logic [LANES-1:0] r_b2;

  state_t          w_state_nxt;
  logic [1:0]      w_phase_nxt;
  logic [W-1:0]    w_word_nxt;
  logic [W-1:0]    w_src;
  logic [1:0]      w_k;
  logic            w_push;
  logic            w_pop;
  logic            w_emit;
  logic [LANES-1:0] w_b1_nxt;
  logic [LANES-1:0] w_b2_nxt;

  // Returns {later, earlier} bit of pair k; MSB-first is LSB-first on the bit-reversed byte.
  function automatic logic [1:0] f_pair(input logic [7:0] b, input logic [1:0] k);
    logic [7:0] v;
    v = b;
    if (MSB_FIRST != 0) begin
      for (int j = 0; j < 8; j++) v[j] = b[7-j];
    end
    return {v[{k, 1'b1}], v[{k, 1'b0}]};
  endfunction

  assign Byte_ready = (r_count != FULL_CNT);
  assign w_push     = Byte_valid && Byte_ready;
  assign Serial_B1  = r_b1;
  assign Serial_B2  = r_b2;
  assign Busy       = (r_state == ST_SHIFT);
  assign Fill_level = r_count;

  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_word_nxt  = r_word;
    w_src       = r_word;
    w_k         = r_phase;
    w_pop       = 1'b0;
    w_emit      = 1'b0;
    w_b1_nxt    = '0;
    w_b2_nxt    = '0;

    if ((r_state == ST_IDLE || r_phase == 2'd0) && Enable && r_count != '0) begin
      w_pop       = 1'b1;
      w_emit      = 1'b1;
      w_src       = r_mem[r_rd_ptr];
      w_word_nxt  = r_mem[r_rd_ptr];
      w_k         = 2'd0;
      w_phase_nxt = 2'd1;
      w_state_nxt = ST_SHIFT;
    end else if (r_state == ST_SHIFT && r_phase != 2'd0) begin
      w_emit      = 1'b1;
      w_phase_nxt = r_phase + 2'd1;
    end else begin
      w_phase_nxt = 2'd0;
      w_state_nxt = ST_IDLE;
    end

    if (w_emit) begin
      for (int l = 0; l < LANES; l++) begin
        {w_b2_nxt[l], w_b1_nxt[l]} = f_pair(w_src[8*l +: 8], w_k);
      end
    end
  end

  always_ff @(posedge TX_DDR_clk or posedge TX_rst) begin
    if (TX_rst) begin
      r_state  <= ST_IDLE;
      r_phase  <= 2'd0;
      r_word   <= '0;
      r_b1     <= '0;
      r_b2     <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_phase  <= w_phase_nxt;
      r_word   <= w_word_nxt;
      r_b1     <= w_b1_nxt;
      r_b2     <= w_b2_nxt;
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CW'(1);
    end
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge TX_DDR_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= TX_BYTE_DATA;
  end

endmodule

// File: tb/tb_hs_lane_serializer.sv
// Directed bench: LSB-first 2-lane instance for most scenarios, plus a 1-lane MSB-first instance.
module tb_hs_lane_serializer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en, vld, rdy, busy;
  logic [15:0] dat;
  logic [1:0]  b1, b2;
  logic [2:0]  fill;

  logic        m_en, m_vld, m_rdy, m_busy;
  logic [7:0]  m_dat;
  logic [0:0]  m_b1, m_b2;
  logic [1:0]  m_fill;

  int n_checks = 0;
  int n_fail   = 0;

  hs_lane_serializer #(.LANES(2), .DEPTH(4), .MSB_FIRST(0)) dut (
    .TX_DDR_clk(clk), .TX_rst(rst), .Enable(en), .TX_BYTE_DATA(dat),
    .Byte_valid(vld), .Byte_ready(rdy), .Serial_B1(b1), .Serial_B2(b2),
    .Busy(busy), .Fill_level(fill)
  );

  hs_lane_serializer #(.LANES(1), .DEPTH(2), .MSB_FIRST(1)) dut_m (
    .TX_DDR_clk(clk), .TX_rst(rst), .Enable(m_en), .TX_BYTE_DATA(m_dat),
    .Byte_valid(m_vld), .Byte_ready(m_rdy), .Serial_B1(m_b1), .Serial_B2(m_b2),
    .Busy(m_busy), .Fill_level(m_fill)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] exp_b1(input logic [15:0] w, input int k);
    logic [1:0] r;
    for (int l = 0; l < 2; l++) r[l] = w[8*l + 2*k];
    return r;
  endfunction

  function automatic logic [1:0] exp_b2(input logic [15:0] w, input int k);
    logic [1:0] r;
    for (int l = 0; l < 2; l++) r[l] = w[8*l + 2*k + 1];
    return r;
  endfunction

  task automatic chk_pair(input string tag, input logic [15:0] w, input int k);
    chk({tag, ".b1"}, 32'(b1), 32'(exp_b1(w, k)));
    chk({tag, ".b2"}, 32'(b2), 32'(exp_b2(w, k)));
    chk({tag, ".busy"}, 32'(busy), 32'd1);
  endtask

  task automatic chk_idle(input string tag, input int f);
    chk({tag, ".b1"}, 32'(b1), 32'd0);
    chk({tag, ".b2"}, 32'(b2), 32'd0);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".fill"}, 32'(fill), 32'(f));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [1:0]  t1_b1 [4];
  logic [1:0]  t1_b2 [4];
  logic [15:0] ws [3];
  logic [15:0] fw [6];
  logic        mb1 [8];
  logic        mb2 [8];

  initial begin
    t1_b1 = '{2'b01, 2'b11, 2'b10, 2'b00};
    t1_b2 = '{2'b00, 2'b10, 2'b11, 2'b01};
    ws    = '{16'h1234, 16'hABCD, 16'h5AF0};
    fw    = '{16'h96C3, 16'h7E18, 16'h5A0F, 16'hE1B4, 16'hFFFF, 16'hFFFF};
    mb1   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    mb2   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    rst = 1'b1; en = 1'b0; vld = 1'b0; dat = '0;
    m_en = 1'b0; m_vld = 1'b0; m_dat = '0;
    repeat (2) tick;
    chk_idle("reset", 0);
    chk("reset.rdy", 32'(rdy), 32'd1);
    rst = 1'b0;
    tick;

    // Single word, hand-computed pairs for {3C,A5}
    en = 1'b1; vld = 1'b1; dat = 16'h3CA5;
    tick;
    vld = 1'b0;
    chk("t1.wr.fill", 32'(fill), 32'd1);
    chk("t1.wr.busy", 32'(busy), 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick;
      chk("t1.b1", 32'(b1), 32'(t1_b1[k]));
      chk("t1.b2", 32'(b2), 32'(t1_b2[k]));
      chk("t1.busy", 32'(busy), 32'd1);
    end
    tick;
    chk_idle("t1.end", 0);

    // Back-to-back streaming of three words
    vld = 1'b1; dat = ws[0];
    tick;
    chk("st.fill0", 32'(fill), 32'd1);
    for (int c = 0; c < 12; c++) begin
      if (c < 2) begin
        vld = 1'b1; dat = ws[c+1];
      end else begin
        vld = 1'b0;
      end
      tick;
      chk_pair("st", ws[c/4], c % 4);
      chk("st.fill", 32'(fill), (c == 0) ? 32'd1 : (c < 4) ? 32'd2 : (c < 8) ? 32'd1 : 32'd0);
    end
    tick;
    chk_idle("st.end", 0);

    // Fill past full with Enable low; extra words must be dropped
    en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      vld = 1'b1; dat = fw[i];
      chk("full.rdy", 32'(rdy), (i < 4) ? 32'd1 : 32'd0);
      tick;
      chk("full.fill", 32'(fill), (i < 4) ? 32'(i + 1) : 32'd4);
    end
    vld = 1'b0;
    chk("full.busy", 32'(busy), 32'd0);
    en = 1'b1;
    for (int c = 0; c < 16; c++) begin
      tick;
      chk_pair("drain", fw[c/4], c % 4);
      if (c == 0) chk("drain.rdy", 32'(rdy), 32'd1);
    end
    tick;
    chk_idle("drain.end", 0);

    // Enable dropped during pair 1 with two words queued
    en = 1'b0;
    vld = 1'b1; dat = 16'h4DB2; tick;
    dat = 16'h8E17; tick;
    vld = 1'b0; en = 1'b1;
    tick;
    chk_pair("en.d0", 16'h4DB2, 0);
    chk("en.fill", 32'(fill), 32'd1);
    en = 1'b0;
    for (int k = 1; k < 4; k++) begin
      tick;
      chk_pair("en.d0", 16'h4DB2, k);
    end
    tick;
    chk_idle("en.idle", 1);
    tick;
    chk_idle("en.hold", 1);
    en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick;
      chk_pair("en.d1", 16'h8E17, k);
    end
    tick;
    chk_idle("en.end", 0);

    // Asynchronous reset during pair 2 with data queued
    en = 1'b0;
    vld = 1'b1; dat = 16'h6699; tick;
    dat = 16'h3355; tick;
    vld = 1'b0; en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick;
      chk_pair("ar", 16'h6699, k);
    end
    #2 rst = 1'b1;
    #1;
    chk_idle("ar.now", 0);
    chk("ar.rdy", 32'(rdy), 32'd1);
    tick;
    #3 rst = 1'b0;
    repeat (3) tick;
    chk_idle("ar.after", 0);
    vld = 1'b1; dat = 16'h00FF;
    tick;
    vld = 1'b0;
    tick;
    chk_pair("ar.new", 16'h00FF, 0);
    repeat (4) tick;
    chk_idle("ar.end", 0);

    // MSB-first single lane: A5 then 80
    m_en = 1'b1; m_vld = 1'b1; m_dat = 8'hA5;
    tick;
    chk("m.fill", 32'(m_fill), 32'd1);
    m_dat = 8'h80;
    for (int c = 0; c < 8; c++) begin
      tick;
      m_vld = 1'b0;
      chk("m.b1", 32'(m_b1), 32'(mb1[c]));
      chk("m.b2", 32'(m_b2), 32'(mb2[c]));
      chk("m.busy", 32'(m_busy), 32'd1);
    end
    tick;
    chk("m.end.busy", 32'(m_busy), 32'd0);
    chk("m.end.b1", 32'(m_b1), 32'd0);
    chk("m.end.rdy", 32'(m_rdy), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hs_lane_serializer.md
# hs_lane_serializer

Parametrised multi-lane HS serializer for the D-PHY transmit driver, running entirely in the TX_DDR_clk domain. Accepts one byte per lane per transfer through a valid/ready handshake into a small word FIFO. Emits each byte as four consecutive bit-pairs on Serial_B1/Serial_B2 per lane, gaplessly while data is available. Sits between the lane-distribution logic and the DDR output stage, and replaces the fixed single-lane serializer with its two-clock byte/DDR hand-off.

## Interface
- LANES, 2, number of data lanes (≥1); each lane carries 8 bits per word
- DEPTH, 4, FIFO depth in words (power of 2, ≥2)
- MSB_FIRST, 0, 0 = bit 0 of each byte transmitted first, 1 = bit 7 first
- TX_DDR_clk  in  1  single clock; all state updates on rising edge
- TX_rst  in  1  asynchronous, active-high reset
- Enable  in  1  permits starting a new byte; a byte already in progress always completes
- TX_BYTE_DATA  in  LANES*8  word; lane i = bits [8i+7:8i]
- Byte_valid  in  1  TX_BYTE_DATA valid this cycle
- Byte_ready  out  1  FIFO can accept; = !full (combinational from registered count)
- Serial_B1  out  LANES  earlier bit of current pair, per lane (registered)
- Serial_B2  out  LANES  later bit of current pair, per lane (registered)
- Busy  out  1  serializer in SHIFT state (registered)
- Fill_level  out  $clog2(DEPTH+1)  words currently held in FIFO

## Operation
- Write: on an edge with Byte_valid && Byte_ready, the word is stored at the write pointer; count += 1. Writes while full are ignored (Byte_ready = 0).
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. A write and a pop on the same edge leave count unchanged.
- FSM states: IDLE, SHIFT. The 2-bit phase counter p holds the index of the next pair to emit.
- IDLE: on an edge with Enable && count≠0: pop word, emit pair 0, p←1, state←SHIFT. Otherwise outputs are held at 0.
- SHIFT, p∈{1,2,3}: emit pair p, p←p+1 (mod 4). Enable and FIFO state are ignored.
- SHIFT, p=0: if Enable && count≠0, pop and emit pair 0, p←1 (back-to-back, no gap). Otherwise drive all Serial outputs to 0 and return to IDLE.
- Pair k per lane:
  - MSB_FIRST=0: B1=bit 2k, B2=bit 2k+1.
  - MSB_FIRST=1: B1=bit 7−2k, B2=bit 6−2k.
- Lanes are shifted in lockstep from the same popped word. Each lane uses its own byte slice.
- Enable deasserted mid-byte: remaining pairs of that byte are still sent, then the FSM returns to IDLE. Remaining FIFO contents are retained.

## Timing
- Reset (asynchronous) values: Serial_B1=0, Serial_B2=0, Busy=0, state=IDLE, p=0, pointers=0, Fill_level=0. Byte_ready=1 once count is 0.
- Reset asserted mid-byte: outputs go to 0 immediately and FIFO contents are discarded.
- Latency: word accepted at edge N into an empty FIFO in IDLE with Enable=1 → popped at edge N+1, pair 0 visible after N+1, pair 3 after N+4.
- Throughput: one word per 4 cycles per lane-set (8 bits/lane/4 clk). Sustained streaming requires count≠0 at each p=0 edge.
- Busy rises with the pop edge that leaves IDLE. It falls on the edge that returns to IDLE, one cycle after pair 3 of the last byte.
- Fill_level updates on the same edge as the write or pop that changes it.
- Full: Byte_ready=0 whenever count=DEPTH, even if a pop occurs on that edge. The freed slot is visible the next cycle.

## Test plan
- Single byte, LANES=2, MSB_FIRST=0: write {8'h3C,8'hA5}. Lane 0 (B1,B2) pairs = (1,0),(1,0),(0,1),(0,1); lane 1 = (0,0),(1,1),(1,1),(0,0). Busy high exactly 4 cycles. Outputs return to 0 after.
- MSB_FIRST=1, write 8'hA5 on lane 0: pairs = (1,0),(1,0),(0,1),(0,1) in bit order 7..0. Check 8'h80 gives (1,0) then three (0,0).
- Streaming: write 3 words back-to-back. 12 consecutive pairs with no idle cycle; Fill_level sequence 1,2,2,…→0. Busy stays high for 12 cycles.
- Full: with Enable=0, write DEPTH+2 words. Byte_ready low after DEPTH accepted, Fill_level=DEPTH, extra words dropped. Enable=1 → exactly DEPTH words emitted in order, pointer wrap exercised.
- Enable dropped at pair 1 with 2 words queued: current byte finishes (pairs 1–3). FSM goes IDLE, Fill_level=1 retained. Re-enable → remaining word emitted.
- Async reset asserted at pair 2 with data queued: outputs 0 and Busy 0 immediately. Fill_level=0 and nothing emitted after release until a new write.
